// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode constants, default widths and the fetch state encoding.
package sisc_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int ADDRSIZE_DEF = 12;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b0001;
    localparam logic [3:0] OP_STR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_XSR = 4'b0110;
    localparam logic [3:0] OP_SHF = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1001;

    typedef enum logic {
        FETCH   = 1'b0,
        STOPPED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_fifo.sv
// Prefetch FIFO holding {pc, word} pairs; flush clears it, push and pop may coincide.
module sisc_fetch_fifo #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int DEPTH    = 4,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic [ADDRSIZE-1:0] push_pc,
    input  logic [WIDTH-1:0]    push_word,
    input  logic                pop,
    output logic [ADDRSIZE-1:0] head_pc,
    output logic [WIDTH-1:0]    head_word,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    logic [WIDTH-1:0]    word_mem_q [DEPTH];
    logic [WIDTH-1:0]    word_mem_d [DEPTH];
    logic [ADDRSIZE-1:0] pc_mem_q   [DEPTH];
    logic [ADDRSIZE-1:0] pc_mem_d   [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        word_mem_d = word_mem_q;
        pc_mem_d   = pc_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_mem_d[wr_ptr_q] = push_word;
                pc_mem_d[wr_ptr_q]   = push_pc;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is reset too so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            word_mem_q <= word_mem_d;
            pc_mem_q   <= pc_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_word = word_mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch: PC, in-order memory reads, PC tag queue, drop accounting and FSM.
// Define SISC_FETCH_PREDECODE_EN to stop fetching when an HLT word is enqueued.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int                 WIDTH    = WIDTH_DEF,
    parameter int                 ADDRSIZE = ADDRSIZE_DEF,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDRSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic                mem_rvalid,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [WIDTH-1:0]    ir_data,
    output logic [ADDRSIZE-1:0] ir_pc,
    input  logic                br_taken,
    input  logic [ADDRSIZE-1:0] br_target,
    input  logic                halt,
    output logic                stopped
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    fetch_state_e        state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [CW-1:0]       infl_q, infl_d, drop_q, drop_d;
    logic [ADDRSIZE-1:0] tag_mem_q [DEPTH];
    logic [ADDRSIZE-1:0] tag_mem_d [DEPTH];
    logic [PW-1:0]       tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [CW-1:0] count;
    logic          full, empty;
    logic          rsp_drop, rsp_keep, push, pop, hlt_enq;
    logic [SW-1:0] occ;

    assign rsp_drop = mem_rvalid & (drop_q != '0);
    assign rsp_keep = mem_rvalid & (drop_q == '0);
    assign occ      = SW'(count) + SW'(infl_q) + SW'(drop_q);
    assign mem_req  = !reset && (state_q == FETCH) && !br_taken && (occ < SW'(DEPTH));
    assign push     = rsp_keep & !br_taken & !full;
    assign pop      = !empty & ir_ready & !br_taken;

`ifdef SISC_FETCH_PREDECODE_EN
    assign hlt_enq = push && (mem_rdata[31:28] == OP_HLT);
`else
    assign hlt_enq = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tag_mem_d = tag_mem_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        infl_d    = infl_q + CW'(mem_req) - CW'(rsp_keep);
        drop_d    = drop_q - CW'(rsp_drop);
        if (mem_req) begin
            tag_mem_d[tag_wr_q] = pc_q;
            tag_wr_d            = tag_wr_q + PW'(1);
            pc_d                = pc_q + ADDRSIZE'(1);
        end
        // Dropped responses still retire their tag so the queue stays aligned.
        if (mem_rvalid) tag_rd_d = tag_rd_q + PW'(1);
        if (br_taken) begin
            pc_d    = br_target;
            drop_d  = drop_q - CW'(rsp_drop) + infl_q - CW'(rsp_keep);
            infl_d  = '0;
            state_d = halt ? STOPPED : FETCH;
        end else if (state_q == FETCH && (halt || hlt_enq)) begin
            state_d = STOPPED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            infl_q   <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            drop_q    <= drop_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_mem_q <= tag_mem_d;
        end
    end

    sisc_fetch_fifo #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (br_taken),
        .push      (push),
        .push_pc   (tag_mem_q[tag_rd_q]),
        .push_word (mem_rdata),
        .pop       (pop),
        .head_pc   (ir_pc),
        .head_word (ir_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign mem_addr = pc_q;
    assign ir_valid = !empty;
    assign stopped  = (state_q == STOPPED);

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: latency-configurable memory model, pop scoreboard, vector tables, corner sequences.
module tb_sisc_fetch_unit;
    import sisc_pkg::*;

    localparam int W = 32;
    localparam int A = 12;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mem_req, mem_rvalid, ir_valid, ir_ready, br_taken, halt, stopped;
    logic [A-1:0] mem_addr, ir_pc, br_target;
    logic [W-1:0] mem_rdata, ir_data;

    always #5 clk = ~clk;

    sisc_fetch_unit #(.WIDTH(W), .ADDRSIZE(A), .DEPTH(D), .RESET_PC(12'h000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_data    (ir_data),
        .ir_pc      (ir_pc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt       (halt),
        .stopped    (stopped)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    int lat      = 1;
    int hlt_addr = -1;

    function automatic logic [31:0] mem_word(input logic [A-1:0] a);
        if (int'(a) == hlt_addr) return 32'h9000_0000;
        return 32'h1000_0003 | (32'(a) << 4);
    endfunction

    logic         pv [4];
    logic [A-1:0] pa [4];

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = '0; end
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                for (int k = 0; k < 4; k++) pv[k] = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end else begin
                mem_rvalid = pv[lat-1];
                mem_rdata  = pv[lat-1] ? mem_word(pa[lat-1]) : '0;
                for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
                pv[0] = 1'b0;
            end
            @(negedge clk);
            if (!reset && mem_req) begin pv[0] = 1'b1; pa[0] = mem_addr; end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [A-1:0] pc;
        logic [W-1:0] w;
    } exp_t;

    exp_t         sbq [$];
    exp_t         sb_e;
    logic         prev_hold = 1'b0;
    logic [A-1:0] prev_pc;
    logic [W-1:0] prev_w;
    int           max_addr = 0;

    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_pc", 32'(ir_pc), 32'(prev_pc));
                check("hold_data", ir_data, prev_w);
            end
            if (ir_valid && ir_ready && !br_taken) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got pc %h with no pending entry", ir_pc);
                end else begin
                    sb_e = sbq.pop_front();
                    check("sb_pc", 32'(ir_pc), 32'(sb_e.pc));
                    check("sb_data", ir_data, sb_e.w);
                end
            end
            if (br_taken) sbq.delete();
            if (mem_req) begin
                sbq.push_back({mem_addr, mem_word(mem_addr)});
                if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            end
            prev_hold = ir_valid && !ir_ready && !br_taken;
            prev_pc   = ir_pc;
            prev_w    = ir_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int l, input int h, input logic rdy);
        reset     = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_vld", 32'(ir_valid), 32'd0);
        br_taken  = 1'b0;
        br_target = '0;
        halt      = 1'b0;
        ir_ready  = rdy;
        lat       = l;
        hlt_addr  = h;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h000);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir_data", ir_data, 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        check("rst_stopped", 32'(stopped), 32'd0);
        max_addr = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic         rdy;
        logic         req;
        logic [A-1:0] addr;
        logic         vld;
        logic [A-1:0] pc;
    } vec_t;

    vec_t tab [12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int enq_cyc;
        int stop_cyc;

        ir_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        halt      = 1'b0;

        // Reset release, 1-cycle memory, always ready.
        tab[0]  = '{1'b1, 1'b1, 12'h000, 1'b0, 12'h000};
        tab[1]  = '{1'b1, 1'b1, 12'h001, 1'b0, 12'h000};
        tab[2]  = '{1'b1, 1'b1, 12'h002, 1'b1, 12'h000};
        tab[3]  = '{1'b1, 1'b1, 12'h003, 1'b1, 12'h001};
        tab[4]  = '{1'b1, 1'b1, 12'h004, 1'b1, 12'h002};
        tab[5]  = '{1'b1, 1'b1, 12'h005, 1'b1, 12'h003};
        // Execute stalled: four requests fill the window, head stays at PC 0.
        tab[6]  = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000};
        tab[7]  = '{1'b0, 1'b1, 12'h001, 1'b0, 12'h000};
        tab[8]  = '{1'b0, 1'b1, 12'h002, 1'b1, 12'h000};
        tab[9]  = '{1'b0, 1'b1, 12'h003, 1'b1, 12'h000};
        tab[10] = '{1'b0, 1'b0, 12'h004, 1'b1, 12'h000};
        tab[11] = '{1'b0, 1'b0, 12'h004, 1'b1, 12'h000};

        for (int t = 0; t < 2; t++) begin
            do_reset(1, -1, tab[t*6].rdy);
            for (int i = 0; i < 6; i++) begin
                ir_ready = tab[t*6+i].rdy;
                @(negedge clk);
                check($sformatf("tab%0d_req", t*6+i), 32'(mem_req), 32'(tab[t*6+i].req));
                check($sformatf("tab%0d_addr", t*6+i), 32'(mem_addr), 32'(tab[t*6+i].addr));
                check($sformatf("tab%0d_vld", t*6+i), 32'(ir_valid), 32'(tab[t*6+i].vld));
                if (tab[t*6+i].vld)
                    check($sformatf("tab%0d_pc", t*6+i), 32'(ir_pc), 32'(tab[t*6+i].pc));
                step();
            end
        end
        ir_ready = 1'b1;
        repeat (6) step();

        // Redirect with three reads in flight on a 3-cycle memory.
        do_reset(3, -1, 1'b1);
        repeat (3) step();
        br_taken  = 1'b1;
        br_target = 12'h100;
        @(negedge clk);
        check("br_req_gated", 32'(mem_req), 32'd0);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        check("br_first_req", 32'(mem_req), 32'd1);
        check("br_first_addr", 32'(mem_addr), 32'h100);
        k = 0;
        do begin
            step();
            @(negedge clk);
            k++;
        end while (!ir_valid && k < 20);
        check("br_valid_delay", 32'(k), 32'd4);
        check("br_ir_pc", 32'(ir_pc), 32'h100);
        check("br_ir_data", ir_data, mem_word(12'h100));
        repeat (10) step();

        // PC wrap at the top of the address space.
        do_reset(1, -1, 1'b1);
        repeat (3) step();
        br_taken  = 1'b1;
        br_target = 12'hFFE;
        step();
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [A-1:0] ea;
            ea = 12'hFFE + A'(i);
            @(negedge clk);
            check($sformatf("wrap_req%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("wrap_addr%0d", i), 32'(mem_addr), 32'(ea));
            step();
        end
        repeat (4) step();

        // External halt alone, then redirect to resume.
        halt = 1'b1;
        step();
        halt = 1'b0;
        @(negedge clk);
        check("halt_stopped", 32'(stopped), 32'd1);
        check("halt_req", 32'(mem_req), 32'd0);
        repeat (4) step();
        @(negedge clk);
        check("halt_hold_req", 32'(mem_req), 32'd0);
        check("halt_drained", 32'(ir_valid), 32'd0);

        // Halt and redirect together: flush, new PC, stay stopped.
        br_taken  = 1'b1;
        br_target = 12'h040;
        step();
        br_taken = 1'b0;
        repeat (3) step();
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 12'h200;
        step();
        halt     = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        check("hb_stopped", 32'(stopped), 32'd1);
        check("hb_req", 32'(mem_req), 32'd0);
        check("hb_addr", 32'(mem_addr), 32'h200);
        check("hb_flushed", 32'(ir_valid), 32'd0);
        repeat (3) step();
        @(negedge clk);
        check("hb_still_idle", 32'(mem_req), 32'd0);
        br_taken  = 1'b1;
        br_target = 12'h010;
        step();
        br_taken = 1'b0;
        @(negedge clk);
        check("resume_stopped", 32'(stopped), 32'd0);
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'h010);
        repeat (6) step();

        // HLT word at address 5.
        do_reset(1, 5, 1'b1);
`ifdef SISC_FETCH_PREDECODE_EN
        enq_cyc  = -100;
        stop_cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (stopped) begin stop_cyc = c; break; end
            if (mem_rvalid && mem_rdata == 32'h9000_0000) enq_cyc = c;
            step();
        end
        check("pd_stop_cycle", 32'(stop_cyc), 32'(enq_cyc + 1));
        repeat (5) step();
        @(negedge clk);
        check("pd_no_req", 32'(mem_req), 32'd0);
        check("pd_max_addr_lt", 32'(max_addr < D + 5), 32'd1);
        br_taken  = 1'b1;
        br_target = 12'h000;
        step();
        br_taken = 1'b0;
        @(negedge clk);
        check("pd_resume_req", 32'(mem_req), 32'd1);
        check("pd_resume_addr", 32'(mem_addr), 32'h000);
        check("pd_resume_run", 32'(stopped), 32'd0);
`else
        enq_cyc  = 0;
        stop_cyc = 0;
        repeat (20) step();
        @(negedge clk);
        check("nopd_running", 32'(stopped), 32'd0);
        check("nopd_past_hlt", 32'(max_addr > D + 5), 32'd1);
`endif
        hlt_addr = -1;
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
